// File: rtl/keypad_event_encoder.sv
// N-key raw level vector to a queued stream of press / release / auto-repeat events.
// Path: two-flop synchroniser, per-key debounce, edge capture, priority arbiter, valid/ready FIFO.
module keypad_event_encoder #(
  parameter int N_KEYS        = 16,
  parameter int CODE_W        = 4,
  parameter int DEBOUNCE      = 3,
  parameter int DEPTH         = 8,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 8,
  parameter int REL_EN        = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] key,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [CODE_W-1:0] ev_code,
  output logic              ev_press,
  output logic              ev_repeat,
  output logic [CODE_W:0]   ev_count,
  output logic              overflow
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              press;
    logic              rpt;
  } event_t;

  logic [N_KEYS-1:0] s1, s2, stable, stable_d;
  logic [N_KEYS-1:0] pend_press, pend_rel;
  logic [DB_W-1:0]   db_cnt [N_KEYS];
  logic [RP_W-1:0]   rep_cnt;
  logic              rep_first;

  event_t            mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  logic [N_KEYS-1:0] rise, fall, clr_press, clr_rel;
  logic              single, rep_req, lost;
  logic              press_any, rel_any;
  logic [CODE_W-1:0] press_idx, rel_idx, held_idx;
  logic              pop, can_push, push;
  event_t            push_ev, head;

  // Edges come from the registered stable vector, which adds the one-cycle pending stage.
  assign rise   = stable & ~stable_d;
  assign fall   = (REL_EN != 0) ? (stable_d & ~stable) : '0;
  assign single = (stable != '0) && ((stable & (stable - 1'b1)) == '0);

  assign rep_req = (REPEAT_DELAY != 0) && single &&
                   (rep_first ? (rep_cnt == RP_W'(REPEAT_PERIOD))
                              : (rep_cnt == RP_W'(REPEAT_DELAY)));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    press_any = 1'b0;
    rel_any   = 1'b0;
    press_idx = '0;
    rel_idx   = '0;
    held_idx  = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pend_press[i]) begin
        press_any = 1'b1;
        press_idx = CODE_W'(i);
      end
      if (pend_rel[i]) begin
        rel_any = 1'b1;
        rel_idx = CODE_W'(i);
      end
      if (stable[i]) held_idx = CODE_W'(i);
    end
  end

  always_comb begin
    push_ev = '{code: held_idx, press: 1'b1, rpt: 1'b1};
    if (press_any)    push_ev = '{code: press_idx, press: 1'b1, rpt: 1'b0};
    else if (rel_any) push_ev = '{code: rel_idx,   press: 1'b0, rpt: 1'b0};
  end

  assign pop       = (count != '0) && ev_ready;
  assign can_push  = (count < CW'(DEPTH)) || pop;
  assign push      = can_push && (press_any || rel_any || rep_req);
  assign clr_press = (push && press_any) ? (N_KEYS'(1) << press_idx) : '0;
  assign clr_rel   = (push && !press_any && rel_any) ? (N_KEYS'(1) << rel_idx) : '0;
  assign lost      = |(rise & pend_press & ~clr_press) | |(fall & pend_rel & ~clr_rel);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      s1         <= '0;
      s2         <= '0;
      stable     <= '0;
      stable_d   <= '0;
      pend_press <= '0;
      pend_rel   <= '0;
      rep_cnt    <= '0;
      rep_first  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      s1       <= key;
      s2       <= s1;
      stable_d <= stable;

      for (int i = 0; i < N_KEYS; i++) begin
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
          stable[i] <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end

      pend_press <= (pend_press & ~clr_press) | rise;
      pend_rel   <= (pend_rel & ~clr_rel) | fall;
      if (lost) overflow <= 1'b1;

      // A repeat request fires whether or not it wins the FIFO slot; losing it is silent.
      if (stable != stable_d) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else if (rep_req) begin
        rep_cnt   <= RP_W'(1);
        rep_first <= 1'b1;
      end else if (single && (REPEAT_DELAY != 0) && (rep_cnt < RP_W'(RP_MAX))) begin
        rep_cnt <= rep_cnt + 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= push_ev;
  end

  assign head      = mem[rd_ptr];
  assign ev_valid  = (count != '0);
  assign ev_code   = ev_valid ? head.code  : '0;
  assign ev_press  = ev_valid ? head.press : 1'b0;
  assign ev_repeat = ev_valid ? head.rpt   : 1'b0;
  assign ev_count  = (CODE_W + 1)'(count);

endmodule

// File: doc/keypad_event_encoder.md
Name: keypad_event_encoder

Overview:
- Parametrised successor to the 16-key input encoder.
- Turns an N-key raw level vector into a queued stream of key events, one event per entry:
  - press, release and auto-repeat events;
  - each event carries the key code.
- Sits between the keypad pins and the command decoder.
- Adds input synchronisation, per-key debounce, auto-repeat and a valid/ready event FIFO, so no keystroke is lost while the consumer is busy.

Parameters:
- N_KEYS, 16, number of raw key inputs (2..64).
- CODE_W, 4, width of the key code; must satisfy 2^CODE_W >= N_KEYS.
- DEBOUNCE, 3, consecutive cycles a new synced level must hold before it is accepted (>=1).
- DEPTH, 8, event FIFO entries (power of two, >=2).
- REPEAT_DELAY, 20, cycles a single held key waits before its first repeat event (0 disables repeat).
- REPEAT_PERIOD, 8, cycles between subsequent repeat events (>=1).
- REL_EN, 1, 1 = generate release events, 0 = press and repeat only.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- key  in  N_KEYS  raw asynchronous key levels; 1 = pressed.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head this cycle.
- ev_code  out  CODE_W  key index of the head event.
- ev_press  out  1  1 = press or repeat, 0 = release.
- ev_repeat  out  1  1 = auto-repeat event.
- ev_count  out  CODE_W+1  current FIFO occupancy (0..DEPTH).
- overflow  out  1  sticky: at least one edge event was lost.

Behaviour:
- Reset (Reset=0 at a rising edge) clears all state, including mid-debounce and mid-repeat:
  - synchroniser flops, stable vector, debounce counters, pending masks, repeat counter, FIFO pointers;
  - all outputs read 0 in the following cycle.
- Synchroniser: two flops per key; s2 is the synced level.
- Debounce, per key:
  - counter cleared whenever s2 == stable[i];
  - otherwise the counter increments;
  - stable[i] <= s2 on the edge where the counter would reach DEBOUNCE.
- Edge detect:
  - stable 0->1 sets pend_press[i];
  - stable 1->0 sets pend_rel[i], only when REL_EN=1.
  - If the same-type pending bit is already set, the new edge is lost and overflow is set.
- Arbiter: at most one push per cycle. Priority order:
  1. lowest-index pend_press;
  2. lowest-index pend_rel;
  3. repeat request.
  - A push clears the serviced pending bit.
  - Pending edge events wait (lossless) while the FIFO cannot accept.
- FIFO accepts a push when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Pop happens when ev_valid & ev_ready.
  - Simultaneous push and pop leaves the count unchanged.
- Repeat:
  - The counter runs only while exactly one key is stable-pressed (popcount==1).
  - It clears on any change of the stable vector.
  - A repeat request is raised when the counter equals REPEAT_DELAY, then every REPEAT_PERIOD cycles after that.
  - The request lives for one cycle. If it is not pushed (FIFO full or an edge event wins arbitration), it is dropped silently and overflow is not set.
- Latency, idle system with empty FIFO: ev_valid rises DEBOUNCE+4 rising edges after the first edge that samples the new key level. The breakdown is:
  - 2 edges synchroniser;
  - DEBOUNCE edges debounce;
  - 1 edge pending;
  - 1 edge FIFO write.
- ev_code, ev_press and ev_repeat reflect the head entry; they are 0 when the FIFO is empty.
- Glitch shorter than DEBOUNCE cycles at s2: no stable change, no event.
- Multiple keys stabilising on the same edge: presses are emitted in ascending index order, one per cycle.
- overflow is cleared only by reset.

Test Plan:
- Reset with key=0 -> all outputs 0. Then key=16'h4000 held, ev_ready=0 -> ev_valid=1 after 7 edges; ev_code=14, ev_press=1, ev_repeat=0; ev_count=1.
- key=16'h4000 for 2 cycles, then 0 (glitch < DEBOUNCE) -> ev_valid stays 0 for 20 cycles.
- key 0 -> 16'h0444 in one cycle, ev_ready=1 -> pops in order: code 2, then 6, then 10, all ev_press=1; on release with REL_EN=1 -> release events 2, 6, 10 with ev_press=0.
- Hold key=16'h0010 for 60 cycles, ev_ready=1 -> press(4); repeat(4) at REPEAT_DELAY after stabilisation, then every 8 cycles (5 repeats in total); release(4) when dropped. Pressing a second key mid-hold stops the repeats.
- ev_ready=0, generate 9 distinct presses -> ev_count saturates at 8, ninth stays pending, overflow=0. Re-press a still-pending key -> overflow=1. Drain the FIFO -> the pending ninth event is delivered.
- Assert Reset=0 for 1 cycle while the FIFO holds 5 events and debounce is mid-count -> next cycle ev_valid=0, ev_count=0, overflow=0; a still-held key regenerates its press after DEBOUNCE+4 edges.
